// File: rtl/down_timer.sv
// ---------------------------------------------------------------------------
// down_timer
//
// Reloadable down-counter with one-shot and periodic modes.
//
// A reload value is captured with `load` and a countdown is launched with
// `start`. While running, every cycle with `tick` high decrements the count.
// When the count is at 1 and another tick arrives, the timer expires: it
// emits a single-cycle `tc` pulse and then either stops at 0 (one-shot) or
// reloads and keeps running (periodic). Three sticky flags report expiry,
// overrun (expiry while the previous one was not yet acknowledged) and
// errors (start with a zero reload value).
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous, active-low reset
//   in       in   WIDTH  reload value, captured when load=1
//   load     in   1      write `in` into the reload register (any state)
//   start    in   1      launch a countdown from the reload register
//   stop     in   1      abort the countdown and return to idle
//   tick     in   1      count enable while running
//   mode     in   1      0 = one-shot, 1 = periodic (sampled at expiry)
//   clr      in   1      clear expired / ovr / err
//   out      out  WIDTH  current count
//   busy     out  1      high while the timer is running
//   tc       out  1      one-cycle terminal-count pulse
//   expired  out  1      sticky: at least one expiry since last clear
//   ovr      out  1      sticky: expiry while expired was already set
//   err      out  1      sticky: start attempted with zero reload value
// ---------------------------------------------------------------------------
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  input  logic             tick,
  input  logic             mode,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tc,
  output logic             expired,
  output logic             ovr,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  // State and datapath registers
  state_t           r_state;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_expired;
  logic             r_ovr;
  logic             r_err;

  // Combinational decode
  state_t           w_state_next;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_start_val;
  logic             w_in_idle;
  logic             w_in_run;
  logic             w_in_done;
  logic             w_start_try;
  logic             w_start_ok;
  logic             w_start_go;
  logic             w_start_bad;
  logic             w_tick_run;
  logic             w_expire;
  logic             w_ovr_set;
  logic             w_busy;

  // -------------------------------------------------------------------------
  // Event decode shared by the next-state and datapath logic.
  // A start that coincides with a load launches from the freshly loaded
  // value, so the launch value bypasses the reload register in that case.
  // In DONE, stop wins over start; in IDLE stop has no effect, so a start
  // there proceeds regardless of stop.
  // -------------------------------------------------------------------------
  always_comb begin
    w_in_idle   = (r_state == ST_IDLE);
    w_in_run    = (r_state == ST_RUN);
    w_in_done   = (r_state == ST_DONE);
    w_start_val = load ? in : r_reload;
    w_start_ok  = (w_start_val != ZERO);
    w_start_try = start && (w_in_idle || (w_in_done && !stop));
    w_start_go  = w_start_try && w_start_ok;
    w_start_bad = w_start_try && !w_start_ok;
    // Stop suppresses any counting, expiry and flag update in RUN.
    w_tick_run  = w_in_run && !stop && tick;
    w_expire    = w_tick_run && (r_count == ONE);
    w_ovr_set   = w_expire && r_expired && !clr;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // One-shot expiry parks in DONE; periodic expiry stays in RUN.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_go) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_next = ST_IDLE;
        end else if (w_expire && !mode) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (stop) begin
          w_state_next = ST_IDLE;
        end else if (w_start_go) begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_busy = (r_state == ST_RUN);
  end

  // -------------------------------------------------------------------------
  // Next count value.
  // In IDLE a plain load is mirrored on the count; a successful start takes
  // precedence (and equals `in` anyway when both happen together).
  // In RUN the count never goes below 0: a zero count (only reachable when
  // a zero reload was written mid-run and then used by a periodic reload)
  // is simply held.
  // Periodic reload uses the reload register as it stood before this edge,
  // so a load in the same cycle only affects the following period.
  // -------------------------------------------------------------------------
  always_comb begin
    w_count_next = r_count;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_go) begin
          w_count_next = w_start_val;
        end else if (load) begin
          w_count_next = in;
        end
      end
      ST_RUN: begin
        if (w_tick_run) begin
          if (r_count > ONE) begin
            w_count_next = r_count - ONE;
          end else if (w_expire) begin
            w_count_next = mode ? r_reload : ZERO;
          end
        end
      end
      ST_DONE: begin
        if (w_start_go) begin
          w_count_next = w_start_val;
        end
      end
      default: begin
        w_count_next = r_count;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Reload register and count register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reload <= ZERO;
      r_count  <= ZERO;
    end else begin
      if (load) begin
        r_reload <= in;
      end
      r_count <= w_count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Terminal-count pulse and sticky flags.
  // A set event in the same cycle as clr wins for that flag only.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tc      <= 1'b0;
      r_expired <= 1'b0;
      r_ovr     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_tc      <= w_expire;
      r_expired <= w_expire    || (r_expired && !clr);
      r_ovr     <= w_ovr_set   || (r_ovr && !clr);
      r_err     <= w_start_bad || (r_err && !clr);
    end
  end

  assign out     = r_count;
  assign busy    = w_busy;
  assign tc      = r_tc;
  assign expired = r_expired;
  assign ovr     = r_ovr;
  assign err     = r_err;

endmodule

// File: tb/tb_down_timer.sv
// ---------------------------------------------------------------------------
// tb_down_timer
//
// Directed scenarios followed by a randomized run, all compared every cycle
// against a behavioural model of the timer written directly from its
// operating rules.
// ---------------------------------------------------------------------------
module tb_down_timer;

  localparam int IDLE = 0;
  localparam int RUN  = 1;
  localparam int DONE = 2;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] in    = 4'd0;
  logic       load  = 1'b0;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic       tick  = 1'b0;
  logic       mode  = 1'b0;
  logic       clr   = 1'b0;
  logic [3:0] out;
  logic       busy;
  logic       tc;
  logic       expired;
  logic       ovr;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int mState;
  int mOut;
  int mReload;
  bit mTc;
  bit mExpired;
  bit mOvr;
  bit mErr;

  down_timer #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .load    (load),
    .start   (start),
    .stop    (stop),
    .tick    (tick),
    .mode    (mode),
    .clr     (clr),
    .out     (out),
    .busy    (busy),
    .tc      (tc),
    .expired (expired),
    .ovr     (ovr),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Single comparison: counts it, and counts and reports a failure.
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".out"},     32'(out),     32'(mOut));
    checkVal({tag, ".busy"},    32'(busy),    32'(mState == RUN));
    checkVal({tag, ".tc"},      32'(tc),      32'(mTc));
    checkVal({tag, ".expired"}, 32'(expired), 32'(mExpired));
    checkVal({tag, ".ovr"},     32'(ovr),     32'(mOvr));
    checkVal({tag, ".err"},     32'(err),     32'(mErr));
  endtask

  task automatic modelReset();
    mState   = IDLE;
    mOut     = 0;
    mReload  = 0;
    mTc      = 1'b0;
    mExpired = 1'b0;
    mOvr     = 1'b0;
    mErr     = 1'b0;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic modelStep();
    int startVal;
    bit startTry;
    bit setErr;
    bit setExp;
    bit setOvr;
    setErr   = 1'b0;
    setExp   = 1'b0;
    setOvr   = 1'b0;
    mTc      = 1'b0;
    startVal = load ? int'(in) : mReload;
    startTry = start && (mState == IDLE || (mState == DONE && !stop));
    if (mState == IDLE && load) mOut = int'(in);
    if (startTry) begin
      if (startVal != 0) begin
        mOut   = startVal;
        mState = RUN;
      end else begin
        setErr = 1'b1;
      end
    end else if (mState == RUN) begin
      if (stop) begin
        mState = IDLE;
      end else if (tick) begin
        if (mOut > 1) begin
          mOut = mOut - 1;
        end else if (mOut == 1) begin
          mTc    = 1'b1;
          setExp = 1'b1;
          setOvr = mExpired && !clr;
          if (mode) begin
            mOut = mReload;
          end else begin
            mOut   = 0;
            mState = DONE;
          end
        end
      end
    end else if (mState == DONE && stop) begin
      mState = IDLE;
    end
    if (load) mReload = int'(in);
    mExpired = setExp || (mExpired && !clr);
    mOvr     = setOvr || (mOvr && !clr);
    mErr     = setErr || (mErr && !clr);
  endtask

  // Drive one cycle of inputs, clock it, and compare all outputs.
  task automatic applyStimulus(input logic l, input logic [3:0] v, input logic s,
                               input logic sp, input logic t, input logic m,
                               input logic c, input string tag);
    load  = l;
    in    = v;
    start = s;
    stop  = sp;
    tick  = t;
    mode  = m;
    clr   = c;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int tcCount;
    int tcAt;

    // Reset, observed before the first clock edge
    #2 rst = 1'b0;
    modelReset();
    #2;
    checkOutput("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;

    // Start with a zero reload register
    applyStimulus(0, 4'd0, 1, 0, 0, 0, 0, "zeroStart");
    checkVal("zeroErr",  32'(err),  32'd1);
    checkVal("zeroBusy", 32'(busy), 32'd0);
    checkVal("zeroOut",  32'(out),  32'd0);
    applyStimulus(0, 4'd0, 0, 0, 0, 0, 1, "zeroClr");
    checkVal("zeroClrErr", 32'(err), 32'd0);

    // One-shot run from 4
    applyStimulus(1, 4'd4, 0, 0, 0, 0, 0, "osLoad");
    applyStimulus(0, 4'd0, 1, 0, 1, 0, 0, "osStart");
    checkVal("osStartOut",  32'(out),  32'd4);
    checkVal("osStartBusy", 32'(busy), 32'd1);
    for (int k = 3; k >= 0; k--) begin
      applyStimulus(0, 4'd0, 0, 0, 1, 0, 0, "osTick");
      checkVal("osOut", 32'(out), 32'(k));
      checkVal("osTc",  32'(tc),  32'(k == 0));
    end
    checkVal("osExpired", 32'(expired), 32'd1);
    checkVal("osBusy",    32'(busy),    32'd0);
    applyStimulus(0, 4'd0, 0, 0, 1, 0, 0, "osAfter");
    checkVal("osTcOnce", 32'(tc), 32'd0);

    // Periodic run with reload 3, nine ticks, no clear
    applyStimulus(1, 4'd3, 0, 1, 0, 1, 1, "perPrep");
    applyStimulus(0, 4'd0, 1, 0, 0, 1, 0, "perStart");
    tcCount = 0;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(0, 4'd0, 0, 0, 1, 1, 0, "perTick");
      if (tc) tcCount++;
      checkVal("perTcSpacing", 32'(tc), 32'(k % 3 == 2));
      if (k == 2) checkVal("perOvrAfterFirst", 32'(ovr), 32'd0);
      if (k == 5) checkVal("perOvrAfterSecond", 32'(ovr), 32'd1);
    end
    checkVal("perTcCount", 32'(tcCount), 32'd3);
    checkVal("perBusy",    32'(busy),    32'd1);
    applyStimulus(0, 4'd0, 0, 1, 0, 0, 1, "perStop");

    // Stop and tick together with the count at 1
    applyStimulus(1, 4'd5, 0, 0, 0, 0, 0, "spLoad");
    applyStimulus(0, 4'd0, 1, 0, 0, 0, 0, "spStart");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 4'd0, 0, 0, 1, 0, 0, "spTick");
    end
    checkVal("spPreOut", 32'(out), 32'd1);
    applyStimulus(0, 4'd0, 1, 1, 1, 0, 0, "spStop");
    checkVal("spBusy",    32'(busy),    32'd0);
    checkVal("spOut",     32'(out),     32'd1);
    checkVal("spTc",      32'(tc),      32'd0);
    checkVal("spExpired", 32'(expired), 32'd0);

    // Gapped ticks from 15: fifteen ticks, two cycles apart
    applyStimulus(1, 4'd15, 0, 0, 0, 0, 0, "gapLoad");
    applyStimulus(0, 4'd0, 1, 0, 0, 0, 0, "gapStart");
    tcAt = -1;
    for (int i = 0; i < 40 && tcAt < 0; i++) begin
      applyStimulus(0, 4'd0, 0, 0, (i % 2 == 0), 0, 0, "gapTick");
      if (tc) tcAt = i;
    end
    checkVal("gapTcCycle", 32'(tcAt), 32'd28);
    checkVal("gapOut",     32'(out),  32'd0);

    // Asynchronous reset in the middle of a run at count 7
    applyStimulus(0, 4'd0, 0, 1, 0, 0, 1, "arStop");
    applyStimulus(1, 4'd9, 0, 0, 0, 0, 0, "arLoad");
    applyStimulus(0, 4'd0, 1, 0, 0, 0, 0, "arStart");
    applyStimulus(0, 4'd0, 0, 0, 1, 0, 0, "arTick");
    applyStimulus(0, 4'd0, 0, 0, 1, 0, 0, "arTick");
    checkVal("arPreOut", 32'(out), 32'd7);
    rst = 1'b0;
    modelReset();
    #2;
    checkOutput("arAsync");
    checkVal("arAsyncOut",  32'(out),  32'd0);
    checkVal("arAsyncBusy", 32'(busy), 32'd0);
    #3;
    rst = 1'b1;
    applyStimulus(0, 4'd0, 0, 0, 1, 0, 0, "arAfter");
    checkVal("arNoTc", 32'(tc), 32'd0);

    // Randomized operation against the model
    for (int n = 0; n < 600; n++) begin
      logic rl;
      logic rs;
      logic rsp;
      logic rt;
      logic rm;
      logic rc;
      logic [3:0] rv;
      rl  = ($urandom_range(0, 7) == 0);
      rv  = 4'($urandom_range(0, 15));
      rs  = ($urandom_range(0, 5) == 0);
      rsp = ($urandom_range(0, 24) == 0);
      rt  = ($urandom_range(0, 3) != 0);
      rm  = 1'($urandom_range(0, 1));
      rc  = ($urandom_range(0, 11) == 0);
      applyStimulus(rl, rv, rs, rsp, rt, rm, rc, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
